game_ctrl: RTL and testbench
============================

# game_ctrl

Game-sequencing block for the single-player pong datapath. It consumes the playfield logic's `hit`/`miss` pulses and produces the `score`, remaining-`ball` count and `rng` word that the playfield logic consumes. A four-state FSM handles start, play, post-miss serve delay and game-over. It also keeps a best-score register that survives restarts and is cleared only by reset.

## Interface
- `SCORE_MAX`, 12: winning score; range 1..15.
- `BALLS_INIT`, 3: balls per game; range 1..3.
- `SERVE_DELAY`, 25_000_000: clk cycles the playfield is frozen after a non-final miss; must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  start/restart request; level, already synchronous to clk.
- `hit`  in  1  paddle-hit indication from playfield; synchronous; may stay high several cycles per event.
- `miss`  in  1  miss indication from playfield; same properties as `hit`.
- `score`  out  4  current score, registered.
- `ball`  out  2  balls remaining, registered.
- `rng`  out  16  free-running LFSR value, registered.
- `play_en`  out  1  high only in PLAY; playfield freezes motion when low.
- `game_over`  out  1  high only in OVER.
- `win`  out  1  high in OVER when `score` ≥ SCORE_MAX.
- `best`  out  4  highest final score since reset.

## Operation
- Edge detection:
  - `hit_prev`, `miss_prev` and `start_prev` are registered every cycle.
  - An event is `x & ~x_prev`.
  - A multi-cycle high level counts as exactly one event.
- FSM states IDLE, PLAY, SERVE, OVER.
  - IDLE: `score`=0, `ball`=BALLS_INIT. On a start event, go to PLAY.
  - PLAY, priority top-down, one action per cycle:
    - Miss event with `ball`==1: `ball`←0, go to OVER.
    - Miss event with `ball`>1: `ball`←`ball`−1, serve counter←SERVE_DELAY−1, go to SERVE.
    - Hit event: `score`←`score`+1. If the new score equals SCORE_MAX, go to OVER.
    - A hit event in the same cycle as a miss event is discarded.
  - SERVE:
    - Counter decrements each cycle.
    - At counter==0, go to PLAY.
    - Hit and miss events are ignored.
  - OVER:
    - On entry, `best`←max(`best`, final score). The final score includes the same-cycle increment on a winning hit.
    - On a start event: `score`←0, `ball`←BALLS_INIT, go to PLAY directly (not via IDLE).
- Start events are ignored in PLAY and SERVE. Hit and miss events are ignored in IDLE and OVER.
- `score` does not wrap: it saturates at 15, which is unreachable when SCORE_MAX ≤ 15.
- LFSR:
  - Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left every clk in all states.
  - Feedback = bit15^bit13^bit12^bit10, inserted at bit0.
  - Period 65535; never reaches all-zero.
- `play_en`, `game_over` and `win` are decoded from the registered state and score, so they carry no combinational path from inputs.

## Timing
- Reset values:
  - state IDLE, `score`=0, `ball`=BALLS_INIT, `rng`=LFSR_SEED.
  - `play_en`=0, `game_over`=0, `win`=0, `best`=0, serve counter 0.
  - All edge-detect registers 0.
  - The input high level is not an edge: if `start` is held high through reset release, it does not start a game until it falls and rises again.
- Latency: an input rising at clock edge k (first sampled high at k) updates `score`/`ball`/state at edge k, visible after k.
- SERVE duration: exactly SERVE_DELAY cycles with `play_en`=0. `play_en` returns high SERVE_DELAY cycles after the miss edge.
- `rng` advances exactly one step per clk. The first post-reset value is shift(LFSR_SEED).
- Asynchronous reset mid-SERVE or mid-PLAY aborts immediately; `best` is cleared as well.

## Test plan
- Reset, then a 1-cycle `start` pulse → next cycle `play_en`=1, `score`=0, `ball`=3.
- In PLAY, hold `hit` high 4 cycles → `score` increments once, 0→1.
- With SERVE_DELAY=8: miss pulse → `ball` 3→2, `play_en`=0 for exactly 8 cycles, then 1. A hit pulse during SERVE leaves `score` unchanged.
- Hit and miss rising in the same cycle with `ball`=1 → `ball`=0, `score` unchanged, `game_over`=1, `win`=0.
- 12 separated hit pulses → `score`=12, `game_over`=1, `win`=1, `best`=12. Then a `start` pulse → `score`=0, `ball`=3, `best` remains 12.
- After reset with seed ACE1, check 70000 cycles of `rng` against a reference model: nonzero throughout and period 65535. Assert `rst` mid-game → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/game_ctrl_if.sv
// Playfield <-> game sequencer signal bundle.
// The playfield side (master) drives start/hit/miss; game_ctrl (slave) returns the game status.
interface game_ctrl_if;
  logic        start;
  logic        hit;
  logic        miss;
  logic [3:0]  score;
  logic [1:0]  ball;
  logic [15:0] rng;
  logic        play_en;
  logic        game_over;
  logic        win;
  logic [3:0]  best;

  modport master (
    output start, hit, miss,
    input  score, ball, rng, play_en, game_over, win, best
  );

  modport slave (
    input  start, hit, miss,
    output score, ball, rng, play_en, game_over, win, best
  );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer for the single-player pong datapath: score/ball bookkeeping,
// serve delay, game-over handling, best-score tracking and a free-running LFSR.
module game_ctrl #(
  parameter int          SCORE_MAX   = 12,
  parameter int          BALLS_INIT  = 3,
  parameter int          SERVE_DELAY = 25_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  localparam int          CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [3:0]  SCORE_WIN  = 4'(SCORE_MAX);
  localparam logic [1:0]  BALL_START = 2'(BALLS_INIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_SERVE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // x^16+x^14+x^13+x^11+1, feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       score_q, score_d;
  logic [1:0]       ball_q, ball_d;
  logic [15:0]      rng_q, rng_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       best_q, best_d;
  logic             play_en_q, play_en_d;
  logic             game_over_q, game_over_d;
  logic             win_q, win_d;
  logic             hit_prev_q, miss_prev_q, start_prev_q;
  logic             arm_q;
  logic [3:0]       score_inc_s;
  logic             hit_ev, miss_ev, start_ev;

  // arm_q masks the first post-reset cycle so a level already high at release is not an edge.
  assign hit_ev      = arm_q & bus.hit   & ~hit_prev_q;
  assign miss_ev     = arm_q & bus.miss  & ~miss_prev_q;
  assign start_ev    = arm_q & bus.start & ~start_prev_q;
  assign score_inc_s = (score_q == 4'd15) ? score_q : score_q + 4'd1;

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    ball_d  = ball_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    rng_d   = lfsr_step(rng_q);

    case (state_q)
      S_IDLE: begin
        score_d = 4'd0;
        ball_d  = BALL_START;
        if (start_ev) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        // A miss wins over a same-cycle hit; the hit is dropped.
        if (miss_ev) begin
          if (ball_q <= 2'd1) begin
            ball_d  = 2'd0;
            state_d = S_OVER;
          end else begin
            ball_d  = ball_q - 2'd1;
            cnt_d   = SERVE_LOAD;
            state_d = S_SERVE;
          end
        end else if (hit_ev) begin
          score_d = score_inc_s;
          if (score_inc_s == SCORE_WIN) begin
            state_d = S_OVER;
          end else begin
            state_d = S_PLAY;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_SERVE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_PLAY;
        end else begin
          cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = S_SERVE;
        end
      end
      S_OVER: begin
        if (start_ev) begin
          score_d = 4'd0;
          ball_d  = BALL_START;
          state_d = S_PLAY;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
        score_d = 4'd0;
        ball_d  = BALL_START;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // Best score latches on entry to OVER, including a same-cycle winning increment.
    if ((state_d == S_OVER) && (state_q != S_OVER) && (score_d > best_q)) begin
      best_d = score_d;
    end else begin
      best_d = best_q;
    end

    play_en_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
    win_d       = (state_d == S_OVER) && (score_d >= SCORE_WIN);
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      score_q      <= 4'd0;
      ball_q       <= BALL_START;
      rng_q        <= LFSR_SEED;
      cnt_q        <= {CNT_W{1'b0}};
      best_q       <= 4'd0;
      play_en_q    <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
      hit_prev_q   <= 1'b0;
      miss_prev_q  <= 1'b0;
      start_prev_q <= 1'b0;
      arm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      ball_q       <= ball_d;
      rng_q        <= rng_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      play_en_q    <= play_en_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
      hit_prev_q   <= bus.hit;
      miss_prev_q  <= bus.miss;
      start_prev_q <= bus.start;
      arm_q        <= 1'b1;
    end
  end

  assign bus.score     = score_q;
  assign bus.ball      = ball_q;
  assign bus.rng       = rng_q;
  assign bus.play_en   = play_en_q;
  assign bus.game_over = game_over_q;
  assign bus.win       = win_q;
  assign bus.best      = best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl with a short serve delay.
module tb_game_ctrl;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  game_ctrl_if bus ();

  game_ctrl #(
    .SCORE_MAX  (12),
    .BALLS_INIT (3),
    .SERVE_DELAY(8),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic start_lvl);
    rst       = 1'b1;
    bus.start = start_lvl;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    cyc();
    cyc();
    nvec++; if (bus.score !== 4'd0) begin nerr++; $display("FAIL reset_score got %0d want 0", bus.score); end
    nvec++; if (bus.ball !== 2'd3) begin nerr++; $display("FAIL reset_ball got %0d want 3", bus.ball); end
    nvec++; if (bus.rng !== 16'hACE1) begin nerr++; $display("FAIL reset_rng got %h want ace1", bus.rng); end
    nvec++; if ({bus.play_en, bus.game_over, bus.win} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {bus.play_en, bus.game_over, bus.win}); end
    nvec++; if (bus.best !== 4'd0) begin nerr++; $display("FAIL reset_best got %0d want 0", bus.best); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_start();
    nvec++; if (bus.play_en !== 1'b0) begin nerr++; $display("FAIL idle_play_en got %b want 0", bus.play_en); end
    pulse_start();
    nvec++; if (bus.play_en !== 1'b1) begin nerr++; $display("FAIL start_play_en got %b want 1", bus.play_en); end
    nvec++; if (bus.score !== 4'd0) begin nerr++; $display("FAIL start_score got %0d want 0", bus.score); end
    nvec++; if (bus.ball !== 2'd3) begin nerr++; $display("FAIL start_ball got %0d want 3", bus.ball); end
  endtask

  task automatic test_hit_hold();
    bus.hit = 1'b1;
    cyc();
    nvec++; if (bus.score !== 4'd1) begin nerr++; $display("FAIL hit_first got %0d want 1", bus.score); end
    cyc();
    cyc();
    cyc();
    bus.hit = 1'b0;
    cyc();
    nvec++; if (bus.score !== 4'd1) begin nerr++; $display("FAIL hit_hold got %0d want 1", bus.score); end
  endtask

  task automatic test_serve();
    int low_cnt;
    bus.miss = 1'b1;
    cyc();
    bus.miss = 1'b0;
    nvec++; if (bus.ball !== 2'd2) begin nerr++; $display("FAIL serve_ball got %0d want 2", bus.ball); end
    low_cnt = (bus.play_en === 1'b0) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      bus.hit = (i == 2);
      cyc();
      if (bus.play_en === 1'b0) low_cnt++;
    end
    bus.hit = 1'b0;
    nvec++; if (low_cnt != 8) begin nerr++; $display("FAIL serve_low_cycles got %0d want 8", low_cnt); end
    cyc();
    nvec++; if (bus.play_en !== 1'b1) begin nerr++; $display("FAIL serve_resume got %b want 1", bus.play_en); end
    nvec++; if (bus.score !== 4'd1) begin nerr++; $display("FAIL serve_hit_ignored got %0d want 1", bus.score); end
  endtask

  task automatic test_hit_miss_same();
    bus.miss = 1'b1;
    cyc();
    bus.miss = 1'b0;
    repeat (8) cyc();
    nvec++; if ({bus.play_en, bus.ball} !== 3'b101) begin nerr++; $display("FAIL last_ball_play got %b want 101", {bus.play_en, bus.ball}); end
    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    cyc();
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    nvec++; if (bus.ball !== 2'd0) begin nerr++; $display("FAIL same_ball got %0d want 0", bus.ball); end
    nvec++; if (bus.score !== 4'd1) begin nerr++; $display("FAIL same_score got %0d want 1", bus.score); end
    nvec++; if ({bus.game_over, bus.win, bus.play_en} !== 3'b100) begin nerr++; $display("FAIL same_flags got %b want 100", {bus.game_over, bus.win, bus.play_en}); end
    nvec++; if (bus.best !== 4'd1) begin nerr++; $display("FAIL same_best got %0d want 1", bus.best); end
  endtask

  task automatic test_win();
    pulse_start();
    nvec++; if ({bus.score, bus.ball, bus.play_en} !== 7'b0000_11_1) begin nerr++; $display("FAIL restart1 got %b want 0000111", {bus.score, bus.ball, bus.play_en}); end
    for (int i = 0; i < 11; i++) begin
      bus.hit = 1'b1;
      cyc();
      bus.hit = 1'b0;
      cyc();
    end
    nvec++; if ({bus.score, bus.game_over} !== 5'b1011_0) begin nerr++; $display("FAIL win_11 got %b want 10110", {bus.score, bus.game_over}); end
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    nvec++; if (bus.score !== 4'd12) begin nerr++; $display("FAIL win_score got %0d want 12", bus.score); end
    nvec++; if ({bus.game_over, bus.win, bus.play_en} !== 3'b110) begin nerr++; $display("FAIL win_flags got %b want 110", {bus.game_over, bus.win, bus.play_en}); end
    nvec++; if (bus.best !== 4'd12) begin nerr++; $display("FAIL win_best got %0d want 12", bus.best); end
    cyc();
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    nvec++; if (bus.score !== 4'd12) begin nerr++; $display("FAIL over_hit_ignored got %0d want 12", bus.score); end
    cyc();
    pulse_start();
    nvec++; if ({bus.score, bus.ball} !== 6'b0000_11) begin nerr++; $display("FAIL restart2 got %b want 000011", {bus.score, bus.ball}); end
    nvec++; if (bus.best !== 4'd12) begin nerr++; $display("FAIL best_kept got %0d want 12", bus.best); end
    nvec++; if ({bus.play_en, bus.game_over, bus.win} !== 3'b100) begin nerr++; $display("FAIL restart_flags got %b want 100", {bus.play_en, bus.game_over, bus.win}); end
  endtask

  task automatic test_async_reset();
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    nvec++; if (bus.score !== 4'd1) begin nerr++; $display("FAIL pre_rst_score got %0d want 1", bus.score); end
    #2;
    rst = 1'b1;
    #1;
    nvec++; if ({bus.score, bus.ball} !== 6'b0000_11) begin nerr++; $display("FAIL arst_score_ball got %b want 000011", {bus.score, bus.ball}); end
    nvec++; if ({bus.play_en, bus.game_over, bus.win} !== 3'b000) begin nerr++; $display("FAIL arst_flags got %b want 000", {bus.play_en, bus.game_over, bus.win}); end
    nvec++; if (bus.best !== 4'd0) begin nerr++; $display("FAIL arst_best got %0d want 0", bus.best); end
    nvec++; if (bus.rng !== 16'hACE1) begin nerr++; $display("FAIL arst_rng got %h want ace1", bus.rng); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_start_held();
    do_reset(1'b1);
    cyc();
    cyc();
    nvec++; if (bus.play_en !== 1'b0) begin nerr++; $display("FAIL held_start got %b want 0", bus.play_en); end
    bus.start = 1'b0;
    cyc();
    pulse_start();
    nvec++; if (bus.play_en !== 1'b1) begin nerr++; $display("FAIL held_restart got %b want 1", bus.play_en); end
  endtask

  task automatic test_lfsr();
    logic [15:0] m;
    int mism;
    int zeros;
    int per;
    mism  = 0;
    zeros = 0;
    per   = 0;
    m     = 16'hACE1;
    rst   = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    nvec++; if (bus.rng !== 16'h59C3) begin nerr++; $display("FAIL lfsr_first got %h want 59c3", bus.rng); end
    m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    for (int i = 2; i <= 70000; i++) begin
      cyc();
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      if (bus.rng !== m) mism++;
      if (bus.rng === 16'h0000) zeros++;
      if ((bus.rng === 16'hACE1) && (per == 0)) per = i;
    end
    nvec++; if (mism != 0) begin nerr++; $display("FAIL lfsr_seq got %0d bad steps want 0", mism); end
    nvec++; if (zeros != 0) begin nerr++; $display("FAIL lfsr_zero got %0d zero values want 0", zeros); end
    nvec++; if (per != 65535) begin nerr++; $display("FAIL lfsr_period got %0d want 65535", per); end
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    test_reset();
    test_start();
    test_hit_hold();
    test_serve();
    test_hit_miss_same();
    test_win();
    test_async_reset();
    test_start_held();
    test_lfsr();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
